// File: rtl/tlb_mp_if.sv
// Shared TLB types and the tlb_mp port bundle.
// Defining TLB_PERF_CNT_EN adds per-port hit/miss counters.
package tlb_mp_pkg;
  typedef struct packed {
    logic        found;
    logic [5:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_result_t;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

interface tlb_mp_if #(
  parameter int TLBNUM = 16,
  parameter int NPORTS = 3
);
  import tlb_mp_pkg::*;
  localparam int TLBIDLEN = $clog2(TLBNUM);

  logic [NPORTS-1:0]       s_valid;
  logic [NPORTS-1:0]       s_hold;
  logic [NPORTS-1:0][18:0] s_vppn;
  logic [NPORTS-1:0]       s_va_bit12;
  logic [NPORTS-1:0][9:0]  s_asid;
  tlb_result_t [NPORTS-1:0] s_result;

  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [31:0] invtlb_va;

  logic                we;
  logic                w_fill;
  logic [TLBIDLEN-1:0] w_index;
  tlb_entry_t          w_entry;
  logic [TLBIDLEN-1:0] fill_index;
  logic [TLBIDLEN-1:0] r_index;
  tlb_entry_t          r_entry;

`ifdef TLB_PERF_CNT_EN
  logic [NPORTS-1:0][31:0] hit_cnt;
  logic [NPORTS-1:0][31:0] miss_cnt;

  modport master (
    output s_valid, s_hold, s_vppn, s_va_bit12, s_asid,
    output invtlb_valid, invtlb_op, invtlb_asid, invtlb_va,
    output we, w_fill, w_index, w_entry, r_index,
    input  s_result, fill_index, r_entry, hit_cnt, miss_cnt
  );
  modport slave (
    input  s_valid, s_hold, s_vppn, s_va_bit12, s_asid,
    input  invtlb_valid, invtlb_op, invtlb_asid, invtlb_va,
    input  we, w_fill, w_index, w_entry, r_index,
    output s_result, fill_index, r_entry, hit_cnt, miss_cnt
  );
`else
  modport master (
    output s_valid, s_hold, s_vppn, s_va_bit12, s_asid,
    output invtlb_valid, invtlb_op, invtlb_asid, invtlb_va,
    output we, w_fill, w_index, w_entry, r_index,
    input  s_result, fill_index, r_entry
  );
  modport slave (
    input  s_valid, s_hold, s_vppn, s_va_bit12, s_asid,
    input  invtlb_valid, invtlb_op, invtlb_asid, invtlb_va,
    input  we, w_fill, w_index, w_entry, r_index,
    output s_result, fill_index, r_entry
  );
`endif
endinterface

// File: rtl/tlb_mp.sv
// Fully-associative multi-port LoongArch TLB with hardware fill victim.
// TLB_PERF_CNT_EN enables per-port hit/miss counters.
module tlb_mp
  import tlb_mp_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int NPORTS = 3,
  localparam int TLBIDLEN = $clog2(TLBNUM)
) (
  input logic   clk,
  input logic   reset,
  tlb_mp_if.slave bus
);
  logic [TLBNUM-1:0] r_e;
  logic [TLBNUM-1:0] r_g;
  logic [TLBNUM-1:0] r_big;
  logic [18:0]       r_vppn [TLBNUM];
  logic [9:0]        r_asid [TLBNUM];
  tlb_page_t         r_p0 [TLBNUM];
  tlb_page_t         r_p1 [TLBNUM];

  logic [TLBIDLEN-1:0] r_fill;
  logic [TLBIDLEN-1:0] r_rr;
  tlb_entry_t          r_rd;
  tlb_result_t [NPORTS-1:0] r_sres;

  function automatic logic f_vm(
    input logic [18:0] a,
    input logic [18:0] b,
    input logic        big
  );
    f_vm = big ? (a[18:9] == b[18:9]) : (a == b);
  endfunction

  logic [NPORTS-1:0][TLBNUM-1:0]   w_hit;
  logic [NPORTS-1:0][TLBIDLEN-1:0] w_sidx;
  tlb_page_t [NPORTS-1:0]          w_pg;
  tlb_result_t [NPORTS-1:0]        w_sres;

  always_comb begin
    w_hit = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int k = 0; k < TLBNUM; k++)
        w_hit[p][k] = r_e[k]
          && f_vm(r_vppn[k], bus.s_vppn[p], r_big[k])
          && (r_g[k] || r_asid[k] == bus.s_asid[p]);
  end

  // descending scan leaves the lowest matching index
  always_comb begin
    w_sidx = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int k = TLBNUM - 1; k >= 0; k--)
        if (w_hit[p][k]) w_sidx[p] = TLBIDLEN'(k);
  end

  always_comb begin
    w_pg = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (r_big[w_sidx[p]] ? bus.s_vppn[p][8] : bus.s_va_bit12[p])
        w_pg[p] = r_p1[w_sidx[p]];
      else
        w_pg[p] = r_p0[w_sidx[p]];
    end
  end

  always_comb begin
    w_sres = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (|w_hit[p]) begin
        w_sres[p].found = 1'b1;
        w_sres[p].index = 6'(w_sidx[p]);
        w_sres[p].ppn   = w_pg[p].ppn;
        w_sres[p].ps    = r_big[w_sidx[p]] ? 6'd21 : 6'd12;
        w_sres[p].plv   = w_pg[p].plv;
        w_sres[p].mat   = w_pg[p].mat;
        w_sres[p].d     = w_pg[p].d;
        w_sres[p].v     = w_pg[p].v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sres <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++)
        if (bus.s_valid[p] && !bus.s_hold[p]) r_sres[p] <= w_sres[p];
    end
  end

  logic [TLBNUM-1:0] w_iam;
  logic [TLBNUM-1:0] w_ivm;
  logic [TLBNUM-1:0] w_inv;

  always_comb begin
    w_iam = '0;
    w_ivm = '0;
    w_inv = '0;
    for (int k = 0; k < TLBNUM; k++) begin
      w_iam[k] = r_asid[k] == bus.invtlb_asid;
      w_ivm[k] = f_vm(r_vppn[k], bus.invtlb_va[31:13], r_big[k]);
      case (bus.invtlb_op)
        5'd0, 5'd1: w_inv[k] = 1'b1;
        5'd2:       w_inv[k] = r_g[k];
        5'd3:       w_inv[k] = !r_g[k];
        5'd4:       w_inv[k] = !r_g[k] && w_iam[k];
        5'd5:       w_inv[k] = !r_g[k] && w_iam[k] && w_ivm[k];
        5'd6:       w_inv[k] = w_ivm[k] && (r_g[k] || w_iam[k]);
        default:    w_inv[k] = 1'b0;
      endcase
    end
  end

  logic [TLBIDLEN-1:0] w_wi;
  logic                w_wr;
  assign w_wi = bus.w_fill ? r_fill : bus.w_index;
  assign w_wr = bus.we && !bus.invtlb_valid;

  always_ff @(posedge clk) begin
    if (reset)                 r_e <= '0;
    else if (bus.invtlb_valid) r_e <= r_e & ~w_inv;
    else if (bus.we)           r_e[w_wi] <= bus.w_entry.e;
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr) begin
      r_vppn[w_wi] <= bus.w_entry.vppn;
      r_asid[w_wi] <= bus.w_entry.asid;
      r_g[w_wi]    <= bus.w_entry.g;
      r_big[w_wi]  <= bus.w_entry.ps != 6'd12;
      r_p0[w_wi]   <= '{bus.w_entry.ppn0, bus.w_entry.plv0,
                        bus.w_entry.mat0, bus.w_entry.d0, bus.w_entry.v0};
      r_p1[w_wi]   <= '{bus.w_entry.ppn1, bus.w_entry.plv1,
                        bus.w_entry.mat1, bus.w_entry.d1, bus.w_entry.v1};
    end
  end

  logic [TLBIDLEN-1:0] w_free;
  logic                w_full;
  assign w_full = &r_e;

  always_comb begin
    w_free = '0;
    for (int k = TLBNUM - 1; k >= 0; k--)
      if (!r_e[k]) w_free = TLBIDLEN'(k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill <= '0;
      r_rr   <= '0;
    end else begin
      r_fill <= w_full ? r_rr : w_free;
      if (w_full && w_wr && bus.w_fill) r_rr <= r_rr + 1'b1;
    end
  end

  tlb_entry_t w_rd;
  always_comb begin
    w_rd      = '0;
    w_rd.e    = r_e[bus.r_index];
    w_rd.vppn = r_vppn[bus.r_index];
    w_rd.ps   = r_big[bus.r_index] ? 6'd21 : 6'd12;
    w_rd.g    = r_g[bus.r_index];
    w_rd.asid = r_asid[bus.r_index];
    {w_rd.ppn0, w_rd.plv0, w_rd.mat0, w_rd.d0, w_rd.v0} = r_p0[bus.r_index];
    {w_rd.ppn1, w_rd.plv1, w_rd.mat1, w_rd.d1, w_rd.v1} = r_p1[bus.r_index];
  end

  always_ff @(posedge clk) begin
    if (reset) r_rd <= '0;
    else       r_rd <= w_rd;
  end

  assign bus.s_result   = r_sres;
  assign bus.fill_index = r_fill;
  assign bus.r_entry    = r_rd;

`ifdef TLB_PERF_CNT_EN
  logic [NPORTS-1:0][31:0] r_hit;
  logic [NPORTS-1:0][31:0] r_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit  <= '0;
      r_miss <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (bus.s_valid[p] && !bus.s_hold[p]) begin
          if (w_sres[p].found) begin
            if (r_hit[p] != '1) r_hit[p] <= r_hit[p] + 32'd1;
          end else begin
            if (r_miss[p] != '1) r_miss[p] <= r_miss[p] + 32'd1;
          end
        end
      end
    end
  end

  assign bus.hit_cnt  = r_hit;
  assign bus.miss_cnt = r_miss;
`endif
endmodule

// File: tb/tb_tlb_mp.sv
// Testbench for tlb_mp: directed scenarios plus random traffic
// checked every cycle against a behavioural TLB model.
module tb_tlb_mp;
  import tlb_mp_pkg::*;
  localparam int N  = 16;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_mp_if #(.TLBNUM(N), .NPORTS(NP)) bus();
  tlb_mp #(.TLBNUM(N), .NPORTS(NP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  bit          m_e  [N];
  bit          m_wr [N];
  tlb_entry_t  m_ent[N];
  int          m_rr;
  tlb_result_t exp_res[NP];
  int          exp_fill;
  tlb_entry_t  exp_r;
  bit          exp_r_known;
  longint      m_hit [NP];
  longint      m_miss[NP];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_vm(logic [18:0] ev, logic [18:0] v, logic [5:0] ps);
    if (ps == 6'd21) return ev[18:9] == v[18:9];
    return ev == v;
  endfunction

  function automatic tlb_result_t m_search(int p);
    tlb_result_t r;
    bit odd;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (m_e[k] && m_vm(m_ent[k].vppn, bus.s_vppn[p], m_ent[k].ps)
          && (m_ent[k].g || m_ent[k].asid == bus.s_asid[p])) begin
        odd = (m_ent[k].ps == 6'd12) ? bus.s_va_bit12[p] : bus.s_vppn[p][8];
        r.found = 1'b1;
        r.index = 6'(k);
        r.ps    = m_ent[k].ps;
        r.ppn   = odd ? m_ent[k].ppn1 : m_ent[k].ppn0;
        r.plv   = odd ? m_ent[k].plv1 : m_ent[k].plv0;
        r.mat   = odd ? m_ent[k].mat1 : m_ent[k].mat0;
        r.d     = odd ? m_ent[k].d1 : m_ent[k].d0;
        r.v     = odd ? m_ent[k].v1 : m_ent[k].v0;
        return r;
      end
    end
    return r;
  endfunction

  function automatic bit m_inv(int k);
    bit g, am, vm;
    g  = m_ent[k].g;
    am = m_ent[k].asid == bus.invtlb_asid;
    vm = m_vm(m_ent[k].vppn, bus.invtlb_va[31:13], m_ent[k].ps);
    case (int'(bus.invtlb_op))
      0, 1:    return 1;
      2:       return g;
      3:       return !g;
      4:       return !g && am;
      5:       return !g && am && vm;
      6:       return vm && (g || am);
      default: return 0;
    endcase
  endfunction

  int nf, tgt, nxt_fill;
  bit full;
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) m_e[k] = 0;
      for (int p = 0; p < NP; p++) begin
        exp_res[p] = '0;
        m_hit[p] = 0;
        m_miss[p] = 0;
      end
      exp_fill = 0;
      exp_r = '0;
      exp_r_known = 1;
      m_rr = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (bus.s_valid[p] && !bus.s_hold[p]) begin
          exp_res[p] = m_search(p);
          if (exp_res[p].found) m_hit[p]++;
          else m_miss[p]++;
        end
      end
      exp_r = m_ent[bus.r_index];
      exp_r.e = m_e[bus.r_index];
      exp_r_known = m_wr[bus.r_index];
      full = 1;
      nf = -1;
      for (int k = 0; k < N; k++) begin
        if (!m_e[k]) begin
          full = 0;
          if (nf < 0) nf = k;
        end
      end
      nxt_fill = full ? m_rr : nf;
      tgt = bus.w_fill ? exp_fill : int'(bus.w_index);
      if (bus.invtlb_valid) begin
        for (int k = 0; k < N; k++)
          if (m_e[k] && m_inv(k)) m_e[k] = 0;
      end else if (bus.we) begin
        m_e[tgt] = bus.w_entry.e;
        m_ent[tgt] = bus.w_entry;
        m_ent[tgt].ps = (bus.w_entry.ps == 6'd12) ? 6'd12 : 6'd21;
        m_wr[tgt] = 1;
        if (full && bus.w_fill) m_rr = (m_rr + 1) % N;
      end
      exp_fill = nxt_fill;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++)
        chk($sformatf("s_result%0d", p), 128'(bus.s_result[p]), 128'(exp_res[p]));
      chk("fill_index", 128'(bus.fill_index), 128'(exp_fill));
      if (exp_r_known) chk("r_entry", 128'(bus.r_entry), 128'(exp_r));
      else chk("r_entry_e", 128'(bus.r_entry.e), 128'(exp_r.e));
`ifdef TLB_PERF_CNT_EN
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("hit_cnt%0d", p), 128'(bus.hit_cnt[p]), 128'(m_hit[p]));
        chk($sformatf("miss_cnt%0d", p), 128'(bus.miss_cnt[p]), 128'(m_miss[p]));
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_valid = '0;
    bus.s_hold = '0;
    bus.s_vppn = '0;
    bus.s_va_bit12 = '0;
    bus.s_asid = '0;
    bus.invtlb_valid = 1'b0;
    bus.invtlb_op = '0;
    bus.invtlb_asid = '0;
    bus.invtlb_va = '0;
    bus.we = 1'b0;
    bus.w_fill = 1'b0;
    bus.w_index = '0;
    bus.w_entry = '0;
    bus.r_index = '0;
  endtask

  function automatic tlb_entry_t mk(logic [18:0] vppn, logic [9:0] asid, bit g,
                                    logic [5:0] ps, logic [19:0] p0, logic [19:0] p1);
    tlb_entry_t t;
    t = '0;
    t.e = 1'b1;
    t.vppn = vppn;
    t.asid = asid;
    t.g = g;
    t.ps = ps;
    t.ppn0 = p0;
    t.v0 = 1'b1;
    t.plv0 = 2'd1;
    t.ppn1 = p1;
    t.v1 = 1'b1;
    t.mat1 = 2'd2;
    t.d1 = 1'b1;
    return t;
  endfunction

  task automatic wr(int idx, tlb_entry_t t);
    bus.we = 1'b1;
    bus.w_fill = 1'b0;
    bus.w_index = 4'(idx);
    bus.w_entry = t;
    step();
    bus.we = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [18:0] pool [6];
  initial begin
    pool[0] = 19'h00100; pool[1] = 19'h00180; pool[2] = 19'h1FF00;
    pool[3] = 19'h1FF80; pool[4] = 19'h12345; pool[5] = 19'h00000;
    do_reset();
    chk_en = 1;
    chk("rst_fill", 128'(bus.fill_index), 128'(0));
    chk("rst_sres0", 128'(bus.s_result[0]), 128'(0));
    chk("rst_re", 128'(bus.r_entry.e), 128'(0));

    wr(3, mk(19'h12345, 10'd5, 0, 6'd12, 20'hAAAAA, 20'h11111));
    bus.s_valid[0] = 1'b1;
    bus.s_vppn[0] = 19'h12345;
    bus.s_asid[0] = 10'd5;
    step();
    chk("t1_found", 128'(bus.s_result[0].found), 128'(1));
    chk("t1_index", 128'(bus.s_result[0].index), 128'(3));
    chk("t1_ppn", 128'(bus.s_result[0].ppn), 128'(20'hAAAAA));
    chk("t1_ps", 128'(bus.s_result[0].ps), 128'(12));
    chk("t1_model_ppn", 128'(exp_res[0].ppn), 128'(20'hAAAAA));
    bus.s_valid[0] = 1'b0;

    wr(4, mk(19'h1FF00, 10'd9, 1, 6'd21, 20'h00123, 20'h00400));
    bus.s_valid[0] = 1'b1;
    bus.s_vppn[0] = 19'h1FF80;
    bus.s_asid[0] = 10'd0;
    step();
    chk("t2_found", 128'(bus.s_result[0].found), 128'(1));
    chk("t2_index", 128'(bus.s_result[0].index), 128'(4));
    chk("t2_ppn", 128'(bus.s_result[0].ppn), 128'(20'h00400));
    chk("t2_ps", 128'(bus.s_result[0].ps), 128'(21));
    bus.s_valid[0] = 1'b0;

    bus.s_valid[1] = 1'b1;
    bus.s_vppn[1] = 19'h12345;
    bus.s_asid[1] = 10'd5;
    step();
    chk("t3_hit", 128'(bus.s_result[1].found), 128'(1));
    bus.s_hold[1] = 1'b1;
    bus.s_vppn[1] = 19'h00001;
    step();
    step();
    chk("t3_held", 128'(bus.s_result[1].index), 128'(3));
    chk("t3_held_found", 128'(bus.s_result[1].found), 128'(1));
    bus.s_hold[1] = 1'b0;
    step();
    chk("t3_miss", 128'(bus.s_result[1]), 128'(0));

    do_reset();
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t4_fill%0d", i), 128'(bus.fill_index), 128'((i < 16) ? i : 0));
      bus.we = 1'b1;
      bus.w_fill = 1'b1;
      bus.w_entry = mk(19'(32'h100 + i), 10'd0, 0, 6'd12, 20'(i), 20'(i));
      step();
      idle();
      step();
    end
    chk("t4_rr", 128'(bus.fill_index), 128'(1));
    chk("t4_model_rr", 128'(exp_fill), 128'(1));
    bus.r_index = 4'd0;
    step();
    chk("t4_rd0", 128'(bus.r_entry.vppn), 128'(19'h110));
    bus.r_index = 4'd1;
    step();
    chk("t4_rd1", 128'(bus.r_entry.vppn), 128'(19'h101));

    do_reset();
    wr(2, mk(19'h00200, 10'd3, 1, 6'd12, 20'h2, 20'h2));
    wr(5, mk(19'h00500, 10'd7, 0, 6'd12, 20'h5, 20'h5));
    bus.invtlb_valid = 1'b1;
    bus.invtlb_op = 5'd4;
    bus.invtlb_asid = 10'd7;
    bus.we = 1'b1;
    bus.w_index = 4'd9;
    bus.w_entry = mk(19'h00900, 10'd7, 0, 6'd12, 20'h9, 20'h9);
    step();
    idle();
    step();
    chk("t5_fill", 128'(bus.fill_index), 128'(0));
    bus.r_index = 4'd5;
    step();
    chk("t5_e5", 128'(bus.r_entry.e), 128'(0));
    bus.r_index = 4'd2;
    step();
    chk("t5_e2", 128'(bus.r_entry.e), 128'(1));
    bus.r_index = 4'd9;
    step();
    chk("t5_e9", 128'(bus.r_entry.e), 128'(0));

    do_reset();
    wr(10, mk(19'h00600, 10'd1, 0, 6'd12, 20'hAAAA0, 20'h1));
    wr(6, mk(19'h00600, 10'd1, 0, 6'd12, 20'h66666, 20'h1));
    for (int i = 0; i < 6; i++) begin
      bus.s_valid[0] = 1'b1;
      bus.s_vppn[0] = (i < 4) ? 19'h00600 : 19'h00601;
      bus.s_asid[0] = 10'd1;
      bus.s_valid[2] = 1'b1;
      bus.s_vppn[2] = 19'h00600;
      bus.s_asid[2] = 10'd1;
      step();
      chk($sformatf("t6_p0_%0d", i), 128'(bus.s_result[0].index), 128'((i < 4) ? 6 : 0));
      chk($sformatf("t6_p2_%0d", i), 128'(bus.s_result[2].index), 128'(6));
    end
`ifdef TLB_PERF_CNT_EN
    chk("t6_hits", 128'(bus.hit_cnt[0]), 128'(4));
    chk("t6_miss", 128'(bus.miss_cnt[0]), 128'(2));
`endif
    idle();

    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        bus.s_valid[p] = $urandom_range(0, 9) < 7;
        bus.s_hold[p] = $urandom_range(0, 9) < 2;
        bus.s_vppn[p] = pool[$urandom_range(0, 5)];
        bus.s_va_bit12[p] = 1'($urandom);
        bus.s_asid[p] = 10'($urandom_range(0, 3));
      end
      bus.we = $urandom_range(0, 9) < 3;
      bus.w_fill = 1'($urandom);
      bus.w_index = 4'($urandom);
      bus.w_entry = mk(pool[$urandom_range(0, 5)], 10'($urandom_range(0, 3)),
                       1'($urandom), ($urandom_range(0, 9) < 5) ? 6'd12 :
                       (($urandom_range(0, 9) < 8) ? 6'd21 : 6'd14),
                       20'($urandom), 20'($urandom));
      bus.w_entry.e = $urandom_range(0, 9) != 0;
      bus.w_entry.plv0 = 2'($urandom);
      bus.w_entry.mat0 = 2'($urandom);
      bus.w_entry.d0 = 1'($urandom);
      bus.invtlb_valid = $urandom_range(0, 99) < 8;
      bus.invtlb_op = 5'($urandom_range(0, 9));
      bus.invtlb_asid = 10'($urandom_range(0, 3));
      bus.invtlb_va = {pool[$urandom_range(0, 5)], 13'($urandom)};
      bus.r_index = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
